// File: rtl/rca_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: time-shares one SLICE-bit ripple-carry adder
// across a WIDTH-bit operation, least-significant slice first.
module rca_seq_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic [SLICE-1:0] sl_a,
   output logic [SLICE-1:0] sl_b,
   output logic             sl_ci,
   input  logic [SLICE-1:0] sl_s,
   input  logic             sl_co
);

   localparam int unsigned NSLICE   = WIDTH / SLICE;
   localparam int unsigned IW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               carry_q, carry_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               co_q, co_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [SLICE-1:0]   sl_a_q, sl_a_d;
   logic [SLICE-1:0]   sl_b_q, sl_b_d;
   logic               sl_ci_q, sl_ci_d;
   logic               accept;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sl_a_q  <= '0;
         sl_b_q  <= '0;
         sl_ci_q <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sl_a_q  <= sl_a_d;
         sl_b_q  <= sl_b_d;
         sl_ci_q <= sl_ci_d;
      end
   end

   // Next-state, slice capture and registered slice-bus drive
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) accept = 1'b1;
         end
         RUN: begin
            s_d[idx_q*SLICE +: SLICE] = sl_s;
            carry_d = sl_co;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
               co_d    = sl_co;
               // Final slice sum bit is the result sign; s_q not yet updated.
               ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                         (sl_s[SLICE-1] != opa_q[WIDTH-1]);
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (start) accept = 1'b1;
            else       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d = RUN;
         opa_d   = a;
         opb_d   = op ? ~b : b;
         carry_d = op ? 1'b1 : ci;
         idx_d   = '0;
      end

      busy_d  = (state_d == RUN);
      done_d  = (state_d == DONE);
      sl_a_d  = '0;
      sl_b_d  = '0;
      sl_ci_d = 1'b0;
      if (state_d == RUN) begin
         sl_a_d  = opa_d[idx_d*SLICE +: SLICE];
         sl_b_d  = opb_d[idx_d*SLICE +: SLICE];
         sl_ci_d = carry_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign s     = s_q;
   assign co    = co_q;
   assign ovf   = ovf_q;
   assign sl_a  = sl_a_q;
   assign sl_b  = sl_b_q;
   assign sl_ci = sl_ci_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_rca_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, op, ci;
   logic [31:0] a, b;
   logic        busy, done, co, ovf, sl_ci, sl_co;
   logic [31:0] s;
   logic [7:0]  sl_a, sl_b, sl_s;

   int total = 0;
   int bad   = 0;

   rca_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .ci(ci),
      .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf),
      .sl_a(sl_a), .sl_b(sl_b), .sl_ci(sl_ci), .sl_s(sl_s), .sl_co(sl_co)
   );

   // Behavioural shared 8-bit adder
   assign {sl_co, sl_s} = 9'(sl_a) + 9'(sl_b) + 9'(sl_ci);

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] s;
      logic        co;
      logic        ovf;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference results from plain arithmetic on the operation itself
   function automatic logic [33:0] model(input logic op_v, input logic [31:0] a_v,
                                         input logic [31:0] b_v, input logic ci_v);
      logic [31:0] r;
      logic        c, v;
      if (op_v) begin
         r = a_v - b_v;
         c = (a_v >= b_v);
         v = (a_v[31] != b_v[31]) && (r[31] != a_v[31]);
      end else begin
         r = a_v + b_v + 32'(ci_v);
         c = 1'((64'(a_v) + 64'(b_v) + 64'(ci_v)) >> 32);
         v = (a_v[31] == b_v[31]) && (r[31] != a_v[31]);
      end
      return {c, v, r};
   endfunction

   // Expected carry into each slice: carry out of the low 8k bits
   function automatic logic [3:0] exp_cis(input logic op_v, input logic [31:0] a_v,
                                          input logic [31:0] b_v, input logic ci_v);
      logic [31:0] bb;
      logic        c0;
      logic [63:0] m;
      logic [3:0]  r;
      bb = op_v ? ~b_v : b_v;
      c0 = op_v ? 1'b1 : ci_v;
      for (int k = 0; k < 4; k++) begin
         m    = (64'd1 << (8*k)) - 64'd1;
         r[k] = 1'(((64'(a_v) & m) + (64'(bb) & m) + 64'(c0)) >> (8*k));
      end
      return r;
   endfunction

   task automatic do_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic ci_v, output logic [31:0] s_r, output logic co_r,
                        output logic ovf_r, output int lat, output int bcnt,
                        output logic [3:0] cis);
      @(negedge clk);
      start = 1'b1; op = op_v; a = a_v; b = b_v; ci = ci_v;
      @(negedge clk);
      start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom; ci = 1'($urandom);
      lat = 1; bcnt = 0; cis = '0;
      while (!done && lat < 20) begin
         if (busy) begin
            bcnt++;
            if (lat <= 4) cis[lat-1] = sl_ci;
         end
         @(negedge clk);
         lat++;
      end
      s_r = s; co_r = co; ovf_r = ovf;
   endtask

   initial begin
      vec_t        vt[10];
      logic [31:0] rs;
      logic        rc, rv;
      int          lat, bcnt, ndone, first_lat, second_lat;
      logic [3:0]  cis;
      logic [33:0] m;
      logic [31:0] s_first, s_second;

      vt[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vt[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vt[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vt[3] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
      vt[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
      vt[5] = '{1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vt[6] = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
      vt[7] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vt[8] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
      vt[9] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

      reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'h1; b = 32'h1; ci = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_s", 64'(s), 64'd0);
      chk("reset_co_ovf", 64'({co, ovf}), 64'd0);
      chk("reset_slbus", 64'({sl_a, sl_b, sl_ci}), 64'd0);
      reset = 1'b0; start = 1'b0;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].ci, rs, rc, rv, lat, bcnt, cis);
         chk($sformatf("vec%0d_s", i), 64'(rs), 64'(vt[i].s));
         chk($sformatf("vec%0d_co", i), 64'(rc), 64'(vt[i].co));
         chk($sformatf("vec%0d_ovf", i), 64'(rv), 64'(vt[i].ovf));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
         chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd4);
         chk($sformatf("vec%0d_slice_ci", i), 64'(cis), 64'(exp_cis(vt[i].op, vt[i].a, vt[i].b, vt[i].ci)));
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 64'({done, busy}), 64'd0);
         chk($sformatf("vec%0d_idle_slbus", i), 64'({sl_a, sl_b, sl_ci}), 64'd0);
         chk($sformatf("vec%0d_s_held", i), 64'(s), 64'(vt[i].s));
      end
      chk("slice_ci_carry_chain", 64'(exp_cis(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0)), 64'(4'b1110));

      // Start pulse during RUN is ignored
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h12345678; b = 32'h11111111; ci = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = 1'b1;
      @(negedge clk); start = 1'b0;
      ndone = 0; first_lat = 0; s_first = '0;
      for (int c = 3; c < 14; c++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) begin first_lat = c; s_first = s; end
         end
         @(negedge clk);
      end
      chk("ignore_start_ndone", 64'(ndone), 64'd1);
      chk("ignore_start_lat", 64'(first_lat), 64'd5);
      chk("ignore_start_s", 64'(s_first), 64'h23456789);

      // Reset during RUN aborts without a done pulse
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h0F0F0F0F; b = 32'h01010101; ci = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_s", 64'(s), 64'd0);
      chk("abort_slbus", 64'({sl_a, sl_b, sl_ci}), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      do_op(1'b0, 32'h1, 32'h1, 1'b0, rs, rc, rv, lat, bcnt, cis);
      chk("after_abort_s", 64'(rs), 64'h2);
      chk("after_abort_lat", 64'(lat), 64'd5);

      // Start held through DONE launches the next operation immediately
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h1; b = 32'h2; ci = 1'b0;
      ndone = 0; first_lat = 0; second_lat = 0; s_first = '0; s_second = '0;
      for (int c = 0; c < 16; c++) begin
         if (c == 1) begin a = 32'hA; b = 32'h5; end
         if (c == 6) start = 1'b0;
         if (done) begin
            ndone++;
            if (ndone == 1) begin first_lat = c; s_first = s; end
            if (ndone == 2) begin second_lat = c; s_second = s; end
         end
         @(negedge clk);
      end
      chk("b2b_ndone", 64'(ndone), 64'd2);
      chk("b2b_first_lat", 64'(first_lat), 64'd5);
      chk("b2b_spacing", 64'(second_lat - first_lat), 64'd5);
      chk("b2b_first_s", 64'(s_first), 64'h3);
      chk("b2b_second_s", 64'(s_second), 64'hF);

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 150; i++) begin
         logic        rop, rci;
         logic [31:0] ra, rb;
         rop = 1'($urandom); rci = 1'($urandom);
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 4))
            0: ra = 32'hFFFFFFFF;
            1: rb = 32'h80000000;
            2: rb = ~ra;
            default: ;
         endcase
         do_op(rop, ra, rb, rci, rs, rc, rv, lat, bcnt, cis);
         m = model(rop, ra, rb, rci);
         chk($sformatf("rnd%0d_result", i), 64'({rc, rv, rs}), 64'(m));
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd5);
         chk($sformatf("rnd%0d_slice_ci", i), 64'(cis), 64'(exp_cis(rop, ra, rb, rci)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
